// File: rtl/mcb_cmd_scheduler_pkg.sv
// Shared types, command codes and request validation for the MCB command scheduler.
// Define MCB_CMD_AUTO_PRECHARGE_EN at build time to select the auto-precharge command codes.
package mcb_cmd_scheduler_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    typedef enum logic {
        SIDE_WR = 1'b0,
        SIDE_RD = 1'b1
    } side_e;

`ifdef MCB_CMD_AUTO_PRECHARGE_EN
    localparam logic [2:0] CMD_INSTR_WR = 3'b010;
    localparam logic [2:0] CMD_INSTR_RD = 3'b011;
`else
    localparam logic [2:0] CMD_INSTR_WR = 3'b000;
    localparam logic [2:0] CMD_INSTR_RD = 3'b001;
`endif

    localparam int FIFO_DEPTH_DEF = 64;

    // A request that can never be issued; it is acked with err instead.
    function automatic logic req_invalid(input logic [31:0] len,
                                         input logic [1:0]  addr_lo,
                                         input logic [31:0] depth);
        return (len == 32'd0) || (len > depth) || (addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/mcb_cmd_scheduler_rr_arbiter.sv
// Two-way round-robin arbiter; rr_last remembers the side granted most recently.
// Grant is combinational; rr_last only moves when the scheduler commits a grant.
module mcb_cmd_scheduler_rr_arbiter
    import mcb_cmd_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       elig_wr,
    input  logic       elig_rd,
    input  logic       commit,
    output logic [1:0] grant
);

    side_e rr_last_q;
    side_e rr_last_d;

    always_comb begin
        grant     = 2'b00;
        rr_last_d = rr_last_q;
        if (elig_wr && elig_rd) begin
            grant = (rr_last_q == SIDE_RD) ? 2'b01 : 2'b10;
        end else if (elig_wr) begin
            grant = 2'b01;
        end else if (elig_rd) begin
            grant = 2'b10;
        end
        if (commit && grant[0]) begin
            rr_last_d = SIDE_WR;
        end else if (commit && grant[1]) begin
            rr_last_d = SIDE_RD;
        end
    end

    // Reset to RD so the write side wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last_q <= SIDE_RD;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

endmodule

// File: rtl/mcb_cmd_scheduler.sv
// MCB user-port command scheduler: round-robin between write and read requesters,
// gated on FIFO readiness. Command codes depend on MCB_CMD_AUTO_PRECHARGE_EN.
module mcb_cmd_scheduler
    import mcb_cmd_scheduler_pkg::*;
#(
    parameter int ADDR_W     = 30,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int CNT_W      = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  logic [CNT_W-1:0]  wr_req_len,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_req_addr,
    input  logic [CNT_W-1:0]  rd_req_len,
    output logic              rd_ack,
    output logic              err,
    input  logic [CNT_W-1:0]  wr_count,
    input  logic [CNT_W-1:0]  rd_count,
    input  logic              cmd_full,
    output logic              cmd_en,
    output logic [2:0]        cmd_instr,
    output logic [5:0]        cmd_bl,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic              busy
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    state_e            state_q, state_d;
    logic              wr_ack_q, wr_ack_d;
    logic              rd_ack_q, rd_ack_d;
    logic              err_q, err_d;
    logic              cmd_en_q, cmd_en_d;
    logic [2:0]        cmd_instr_q, cmd_instr_d;
    logic [5:0]        cmd_bl_q, cmd_bl_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;

    logic              wr_bad, rd_bad;
    logic              wr_elig, rd_elig;
    logic              commit;
    logic [CNT_W-1:0]  rd_room;
    logic [1:0]        grant;

    // A side is masked during its own ack cycle so a held req is not seen twice.
    always_comb begin
        wr_bad  = req_invalid(32'(wr_req_len), wr_req_addr[1:0], 32'(FIFO_DEPTH));
        rd_bad  = req_invalid(32'(rd_req_len), rd_req_addr[1:0], 32'(FIFO_DEPTH));
        rd_room = DEPTH_C - rd_count;
        wr_elig = (state_q == ST_IDLE) && wr_req && !wr_ack_q
                  && (wr_bad || (wr_count >= wr_req_len));
        rd_elig = (state_q == ST_IDLE) && rd_req && !rd_ack_q
                  && (rd_bad || (rd_room >= rd_req_len));
        commit  = wr_elig || rd_elig;
    end

    mcb_cmd_scheduler_rr_arbiter u_arb (
        .clk     (clk),
        .reset   (reset),
        .elig_wr (wr_elig),
        .elig_rd (rd_elig),
        .commit  (commit),
        .grant   (grant)
    );

    always_comb begin
        state_d     = state_q;
        wr_ack_d    = 1'b0;
        rd_ack_d    = 1'b0;
        err_d       = 1'b0;
        cmd_en_d    = 1'b0;
        cmd_instr_d = cmd_instr_q;
        cmd_bl_d    = cmd_bl_q;
        cmd_addr_d  = cmd_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (grant[0]) begin
                    wr_ack_d = 1'b1;
                    err_d    = wr_bad;
                    if (!wr_bad) begin
                        cmd_instr_d = CMD_INSTR_WR;
                        cmd_bl_d    = wr_req_len[5:0] - 6'd1;
                        cmd_addr_d  = wr_req_addr;
                        state_d     = ST_ISSUE;
                    end
                end else if (grant[1]) begin
                    rd_ack_d = 1'b1;
                    err_d    = rd_bad;
                    if (!rd_bad) begin
                        cmd_instr_d = CMD_INSTR_RD;
                        cmd_bl_d    = rd_req_len[5:0] - 6'd1;
                        cmd_addr_d  = rd_req_addr;
                        state_d     = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (!cmd_full) begin
                    cmd_en_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wr_ack_q    <= 1'b0;
            rd_ack_q    <= 1'b0;
            err_q       <= 1'b0;
            cmd_en_q    <= 1'b0;
            cmd_instr_q <= 3'b000;
            cmd_bl_q    <= 6'd0;
            cmd_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ack_q    <= wr_ack_d;
            rd_ack_q    <= rd_ack_d;
            err_q       <= err_d;
            cmd_en_q    <= cmd_en_d;
            cmd_instr_q <= cmd_instr_d;
            cmd_bl_q    <= cmd_bl_d;
            cmd_addr_q  <= cmd_addr_d;
        end
    end

    assign wr_ack    = wr_ack_q;
    assign rd_ack    = rd_ack_q;
    assign err       = err_q;
    assign cmd_en    = cmd_en_q;
    assign cmd_instr = cmd_instr_q;
    assign cmd_bl    = cmd_bl_q;
    assign cmd_addr  = cmd_addr_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mcb_cmd_scheduler.sv
// Scoreboard bench for mcb_cmd_scheduler: directed scenarios plus randomized traffic
// checked by a monitor against a behavioural model of grants, errors and commands.
`timescale 1ns/1ps
module tb_mcb_cmd_scheduler;

    localparam int ADDR_W = 30;
    localparam int DEPTH  = 64;
    localparam int CNT_W  = 7;

`ifdef MCB_CMD_AUTO_PRECHARGE_EN
    localparam logic [2:0] EXP_WR = 3'b010;
    localparam logic [2:0] EXP_RD = 3'b011;
`else
    localparam logic [2:0] EXP_WR = 3'b000;
    localparam logic [2:0] EXP_RD = 3'b001;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              wr_req = 1'b0, rd_req = 1'b0;
    logic [ADDR_W-1:0] wr_req_addr = '0, rd_req_addr = '0;
    logic [CNT_W-1:0]  wr_req_len = '0, rd_req_len = '0;
    logic [CNT_W-1:0]  wr_count = '0, rd_count = '0;
    logic              cmd_full = 1'b0;
    logic              wr_ack, rd_ack, err, cmd_en, busy;
    logic [2:0]        cmd_instr;
    logic [5:0]        cmd_bl;
    logic [ADDR_W-1:0] cmd_addr;

    mcb_cmd_scheduler #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_req_addr(wr_req_addr), .wr_req_len(wr_req_len), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len), .rd_ack(rd_ack),
        .err(err), .wr_count(wr_count), .rd_count(rd_count), .cmd_full(cmd_full),
        .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_addr(cmd_addr),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              bad;
        logic [ADDR_W-1:0] addr;
        int                len;
    } req_t;

    typedef struct {
        logic [2:0]        instr;
        logic [5:0]        bl;
        logic [ADDR_W-1:0] addr;
    } cmd_t;

    req_t wr_exp[$];
    req_t rd_exp[$];
    cmd_t cmd_exp[$];
    int   glog[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic is_bad(input int len, input logic [1:0] lo);
        return (len < 1) || (len > DEPTH) || (lo != 2'b00);
    endfunction

    // ---------------- monitor / reference model ----------------
    logic m_busy = 1'b0;
    logic m_last = 1'b1;
    logic exp_cmd = 1'b0, exp_ack = 1'b0;
    logic prev_ew = 1'b0, prev_er = 1'b0;

    task automatic mon_ack(input logic side, inout logic exp_err);
        req_t r;
        cmd_t c;
        check(side ? "rd_ack_has_request" : "wr_ack_has_request",
              side ? (rd_exp.size() > 0) : (wr_exp.size() > 0), 1);
        if (side ? (rd_exp.size() == 0) : (wr_exp.size() == 0)) return;
        r = side ? rd_exp.pop_front() : wr_exp.pop_front();
        exp_err = r.bad;
        check("acked_side_was_eligible", side ? prev_er : prev_ew, 1);
        if (prev_ew && prev_er) check("round_robin_side", side, !m_last);
        m_last = side;
        glog.push_back(int'(side));
        if (!r.bad) begin
            c.instr = side ? EXP_RD : EXP_WR;
            c.addr  = r.addr;
            c.bl    = 6'((r.len - 1) % 64);
            cmd_exp.push_back(c);
            m_busy = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        logic ew, er, exp_err;
        cmd_t c;
        if (reset) begin
            m_busy = 1'b0; m_last = 1'b1;
            exp_cmd = 1'b0; exp_ack = 1'b0; prev_ew = 1'b0; prev_er = 1'b0;
            wr_exp.delete(); rd_exp.delete(); cmd_exp.delete();
        end else begin
            check("cmd_en_timing", cmd_en, exp_cmd);
            if (cmd_en) begin
                check("cmd_expected", cmd_exp.size() > 0, 1);
                if (cmd_exp.size() > 0) begin
                    c = cmd_exp.pop_front();
                    check("cmd_instr", cmd_instr, c.instr);
                    check("cmd_bl", cmd_bl, c.bl);
                    check("cmd_addr", cmd_addr, c.addr);
                end
                m_busy = 1'b0;
            end
            check("ack_timing", wr_ack | rd_ack, exp_ack);
            check("ack_onehot", wr_ack & rd_ack, 0);
            exp_err = 1'b0;
            if (wr_ack) mon_ack(1'b0, exp_err);
            if (rd_ack) mon_ack(1'b1, exp_err);
            check("err", err, exp_err);
            check("busy", busy, m_busy);
            ew = !m_busy && wr_req && !wr_ack
                 && (is_bad(int'(wr_req_len), wr_req_addr[1:0]) || (int'(wr_count) >= int'(wr_req_len)));
            er = !m_busy && rd_req && !rd_ack
                 && (is_bad(int'(rd_req_len), rd_req_addr[1:0]) || ((DEPTH - int'(rd_count)) >= int'(rd_req_len)));
            exp_ack = ew | er;
            exp_cmd = m_busy && !cmd_full;
            prev_ew = ew;
            prev_er = er;
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic side, input logic [ADDR_W-1:0] addr, input int len,
                         output int cyc);
        req_t r;
        logic got;
        r.bad = is_bad(len, addr[1:0]); r.addr = addr; r.len = len;
        if (side) begin
            rd_exp.push_back(r); rd_req_addr = addr; rd_req_len = CNT_W'(len); rd_req = 1'b1;
        end else begin
            wr_exp.push_back(r); wr_req_addr = addr; wr_req_len = CNT_W'(len); wr_req = 1'b1;
        end
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            got = side ? rd_ack : wr_ack;
        end
        check(side ? "rd_ack_within_bound" : "wr_ack_within_bound", got, 1);
        if (side) rd_req = 1'b0; else wr_req = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        wr_req = 1'b0; rd_req = 1'b0; cmd_full = 1'b0;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic rand_driver(input logic side, input int n);
        int cyc, len, sel;
        logic [ADDR_W-1:0] addr;
        for (int k = 0; k < n; k++) begin
            len  = $urandom_range(1, DEPTH);
            addr = ADDR_W'({$urandom_range(0, 32'h0FFF_FFFF), 2'b00});
            sel  = $urandom_range(0, 19);
            if (sel == 0) len = 0;
            else if (sel == 1) len = $urandom_range(DEPTH + 1, 127);
            else if (sel == 2) addr[1:0] = 2'($urandom_range(1, 3));
            issue(side, addr, len, cyc);
            tick($urandom_range(0, 3));
        end
    endtask

    bit rand_done;

    initial begin
        int cyc, seen;
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, seen;
        tick(3);
        check("reset_wr_ack", wr_ack, 0);
        check("reset_cmd_en", cmd_en, 0);
        check("reset_busy", busy, 0);
        check("reset_cmd_addr", cmd_addr, 0);
        reset = 1'b0;
        tick(1);

        // 1: basic write, ack at +1, cmd_en at +2
        wr_count = 7'd16;
        issue(1'b0, 30'h100, 16, cyc);
        check("t1_ack_latency", cyc, 1);
        tick(1);
        check("t1_cmd_en", cmd_en, 1);
        check("t1_instr", cmd_instr, EXP_WR);
        check("t1_bl", cmd_bl, 15);
        check("t1_addr", cmd_addr, 30'h100);

        // 2: write gated on FIFO occupancy
        wr_count = 7'd8;
        fork
            issue(1'b0, 30'h200, 16, cyc);
            begin tick(10); wr_count = 7'd16; end
        join
        check("t2_ack_after_count", cyc, 11);
        tick(2);

        // 3: alternating grants from a fresh reset
        do_reset();
        wr_count = 7'd64; rd_count = 7'd0;
        glog.delete();
        fork
            begin issue(1'b0, 30'h1000, 8, cyc); issue(1'b0, 30'h1100, 32, cyc); end
            begin issue(1'b1, 30'h2000, 4, cyc); issue(1'b1, 30'h2100, 64, cyc); end
        join
        tick(3);
        check("t3_grant_count", glog.size(), 4);
        for (int i = 0; i < 4 && i < glog.size(); i++) check("t3_grant_order", glog[i], i % 2);

        // 4: cmd_full back-pressure
        cmd_full = 1'b1;
        issue(1'b1, 30'h3000, 8, cyc);
        seen = 0;
        for (int i = 0; i < 5; i++) begin tick(1); seen += int'(cmd_en); end
        check("t4_no_cmd_while_full", seen, 0);
        cmd_full = 1'b0;
        tick(1);
        check("t4_cmd_en", cmd_en, 1);
        check("t4_bl", cmd_bl, 7);
        check("t4_addr", cmd_addr, 30'h3000);
        tick(2);

        // 5: rejected reads, then a full-depth read
        issue(1'b1, 30'h300, 0, cyc);    check("t5_err_len0", err, 1);
        issue(1'b1, 30'h300, 65, cyc);   check("t5_err_len65", err, 1);
        issue(1'b1, 30'h102, 16, cyc);   check("t5_err_misaligned", err, 1);
        rd_count = 7'd0;
        issue(1'b1, 30'h400, 64, cyc);   check("t5_valid_no_err", err, 0);
        tick(1);
        check("t5_cmd_en", cmd_en, 1);
        check("t5_bl63", cmd_bl, 63);
        tick(2);

        // randomized traffic
        rand_done = 1'b0;
        fork
            begin
                fork
                    rand_driver(1'b0, 40);
                    rand_driver(1'b1, 40);
                join
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    tick(1);
                    wr_count = CNT_W'($urandom_range(0, DEPTH));
                    rd_count = CNT_W'($urandom_range(0, DEPTH));
                    cmd_full = ($urandom_range(0, 3) == 0);
                end
            end
        join
        cmd_full = 1'b0;
        tick(5);
        check("rand_cmds_drained", cmd_exp.size(), 0);

        // 6: reset during a stalled issue drops the command
        wr_count = 7'd64;
        cmd_full = 1'b1;
        issue(1'b0, 30'h500, 8, cyc);
        reset = 1'b1;
        tick(1);
        check("t6_wr_ack", wr_ack, 0);
        check("t6_err", err, 0);
        check("t6_cmd_en", cmd_en, 0);
        check("t6_instr", cmd_instr, 0);
        check("t6_bl", cmd_bl, 0);
        check("t6_addr", cmd_addr, 0);
        check("t6_busy", busy, 0);
        reset = 1'b0;
        cmd_full = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin tick(1); seen += int'(cmd_en); end
        check("t6_no_cmd_after_reset", seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
